// File: rtl/nic_stream_pkg.sv
// Shared stream and rate-limit types for the NIC transmit path.
// Flit and settings layouts are common to the shaper and its token bucket.
package nic_stream_pkg;

    localparam int DATA_W = 64;
    localparam int KEEP_W = DATA_W / 8;
    localparam int RL_W   = 8;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } flit_t;

    typedef struct packed {
        logic [RL_W-1:0] inc;
        logic [RL_W-1:0] period;
        logic [RL_W-1:0] size;
    } rlimit_t;

endpackage

// File: rtl/nic_rlimit_bucket.sv
// Token bucket: a free-running refill period counter plus a saturating token
// counter. Settings are used live every cycle.
module nic_rlimit_bucket
    import nic_stream_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  rlimit_t         settings,
    input  logic            grant,
    output logic [RL_W-1:0] tokens,
    output logic            tokens_nonzero
);

    logic [RL_W-1:0] cnt;
    logic            refill;
    logic [RL_W:0]   sum;
    logic [RL_W:0]   capped;

    // A period lowered below cnt is not caught early: cnt runs on and wraps.
    assign refill = (cnt == settings.period);

    // One extra bit so inc + tokens cannot overflow before the clamp.
    always_comb begin
        sum    = {1'b0, tokens} - {{RL_W{1'b0}}, grant}
                 + (refill ? {1'b0, settings.inc} : {(RL_W+1){1'b0}});
        capped = sum;
        if (sum > {1'b0, settings.size}) begin
            capped = {1'b0, settings.size};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt    <= '0;
            tokens <= '0;
        end else begin
            cnt    <= refill ? '0 : cnt + 1'b1;
            tokens <= capped[RL_W-1:0];
        end
    end

    assign tokens_nonzero = (tokens != '0);

endmodule

// File: rtl/nic_tx_rate_limiter.sv
// NIC transmit shaper: meters TX engine flits onto net_out through a token
// bucket, one token per flit, and counts delivered packets.
module nic_tx_rate_limiter #(
    parameter int DATA_W = nic_stream_pkg::DATA_W,
    parameter int KEEP_W = nic_stream_pkg::KEEP_W,
    parameter int RL_W   = nic_stream_pkg::RL_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_bits_data,
    input  logic [KEEP_W-1:0] in_bits_keep,
    input  logic              in_bits_last,
    output logic              net_out_valid,
    input  logic              net_out_ready,
    output logic [DATA_W-1:0] net_out_bits_data,
    output logic [KEEP_W-1:0] net_out_bits_keep,
    output logic              net_out_bits_last,
    input  logic [RL_W-1:0]   rlimit_inc,
    input  logic [RL_W-1:0]   rlimit_period,
    input  logic [RL_W-1:0]   rlimit_size,
    output logic [RL_W-1:0]   tokens,
    output logic [31:0]       pkt_count
);

    nic_stream_pkg::flit_t   out_q;
    nic_stream_pkg::flit_t   in_flit;
    nic_stream_pkg::rlimit_t settings;
    logic                    tokens_nonzero;
    logic                    grant;

    always_comb begin
        settings        = '0;
        settings.inc    = rlimit_inc;
        settings.period = rlimit_period;
        settings.size   = rlimit_size;
        in_flit         = '0;
        in_flit.data    = in_bits_data;
        in_flit.keep    = in_bits_keep;
        in_flit.last    = in_bits_last;
    end

    // Handshake: a flit moves on a cycle where valid and ready are both high;
    // ready never looks at valid. While reset is low in_ready stays high so
    // upstream drains into the discarded in-flight state.
    assign in_ready = !reset || (tokens_nonzero && (!net_out_valid || net_out_ready));
    assign grant    = in_valid && in_ready;

    nic_rlimit_bucket u_bucket (
        .clock          (clock),
        .reset          (reset),
        .settings       (settings),
        .grant          (grant),
        .tokens         (tokens),
        .tokens_nonzero (tokens_nonzero)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            net_out_valid <= 1'b0;
            out_q         <= '0;
            pkt_count     <= '0;
        end else begin
            if (grant) begin
                out_q         <= in_flit;
                net_out_valid <= 1'b1;
            end else if (net_out_ready) begin
                net_out_valid <= 1'b0;
            end
            if (net_out_valid && net_out_ready && out_q.last) begin
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end

    assign net_out_bits_data = out_q.data;
    assign net_out_bits_keep = out_q.keep;
    assign net_out_bits_last = out_q.last;

endmodule
